// File: rtl/shake_pkg.sv
// Shared SHAKE constants, absorb state encoding and padding bytes.
package shake_pkg;

  localparam int SHAKE_W         = 64;
  localparam int RATE_WORDS_128  = 21;
  localparam int RATE_WORDS_256  = 17;

  localparam logic [7:0] SHAKE_DS_PAD    = 8'h1F;
  localparam logic [7:0] SHAKE_FINAL_PAD = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    FULL
  } absorb_state_t;

endpackage

// File: rtl/absorb_fsm_if.sv
// Input stream and block handshake bundle for absorb_fsm.
// slave is the loader's view, master is the environment's view.
interface absorb_fsm_if
  import shake_pkg::*;
#(
  parameter int W          = SHAKE_W,
  parameter int RATE_WORDS = RATE_WORDS_128
);

  localparam int KW = $clog2(W / 8) + 1;

  logic [W-1:0]            data_in;
  logic                    valid_in;
  logic                    ready_out;
  logic                    last_in;
  logic [KW-1:0]           last_bytes_in;
  logic [RATE_WORDS*W-1:0] block_out;
  logic                    block_valid;
  logic                    block_ack;
  logic                    last_block_out;

  modport slave (
    input  data_in, valid_in, last_in, last_bytes_in, block_ack,
    output ready_out, block_out, block_valid, last_block_out
  );

  modport master (
    output data_in, valid_in, last_in, last_bytes_in, block_ack,
    input  ready_out, block_out, block_valid, last_block_out
  );

endinterface

// File: rtl/absorb_buffer.sv
// Rate-block register array: one indexed write port, flat full-block read.
module absorb_buffer #(
  parameter int W          = 64,
  parameter int RATE_WORDS = 21
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       we,
  input  logic [((RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1)-1:0] idx,
  input  logic [W-1:0]                               wdata,
  output logic [RATE_WORDS*W-1:0]                    block_out
);

  localparam int IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;

  logic [W-1:0] mem [RATE_WORDS];

  // Word storage; an out-of-range index simply matches no entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      for (int unsigned i = 0; i < RATE_WORDS; i++) begin
        if (idx == IDX_W'(i)) mem[i] <= wdata;
      end
    end
  end

  // Flatten the array, word i at bits [i*W +: W]
  always_comb begin
    block_out = '0;
    for (int unsigned i = 0; i < RATE_WORDS; i++) begin
      block_out[i*W +: W] = mem[i];
    end
  end

endmodule

// File: rtl/absorb_fsm.sv
// SHAKE input loader: packs stream words into a rate block, pads the
// final block and hands it to the permutation over valid/ack.
// Build option ABSORB_PAD_EN: when defined, SHAKE padding (0x1F ... 0x80)
// is inserted here; when undefined the caller supplies padded data.
module absorb_fsm
  import shake_pkg::*;
#(
  parameter int W          = SHAKE_W,
  parameter int RATE_WORDS = RATE_WORDS_128
) (
  input  logic        clk,
  input  logic        rst_n,
  absorb_fsm_if.slave bus
);

  localparam int NB    = W / 8;
  localparam int CNT_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_WORDS - 1);

  absorb_state_t           state;
  logic [CNT_W-1:0]        cnt;
  logic                    block_valid_q;
  logic                    last_block_q;
  logic                    accept;
  logic                    at_last;
  logic                    buf_we;
  logic [W-1:0]            buf_wdata;
  logic [W-1:0]            last_word;
  logic [W-1:0]            pad_word;
  logic [RATE_WORDS*W-1:0] block_q;

`ifdef ABSORB_PAD_EN
  logic                    pad_done;
  logic                    pad_owed;
  int unsigned             last_k;
`else
  logic                    unused_last_bytes;
  assign unused_last_bytes = ^bus.last_bytes_in;
`endif

  assign bus.ready_out      = (state == FILL);
  assign bus.block_valid    = block_valid_q;
  assign bus.last_block_out = last_block_q;
  assign bus.block_out      = block_q;

  // Accept strobe and final-slot decode
  always_comb begin
    accept  = bus.valid_in && (state == FILL);
    at_last = (cnt == LAST_IDX);
  end

  // Final message word: truncate to k bytes and insert padding bytes
  always_comb begin
    last_word = bus.data_in;
`ifdef ABSORB_PAD_EN
    last_k = 32'(bus.last_bytes_in);
    for (int unsigned b = 0; b < NB; b++) begin
      if (b >= last_k) last_word[b*8 +: 8] = 8'h00;
      if (b == last_k) last_word[b*8 +: 8] = last_word[b*8 +: 8] | SHAKE_DS_PAD;
    end
    if (at_last && (last_k < NB))
      last_word[W-1 -: 8] = last_word[W-1 -: 8] | SHAKE_FINAL_PAD;
`endif
  end

  // Generated padding word for the PAD state
  always_comb begin
    pad_word = '0;
`ifdef ABSORB_PAD_EN
    if (!pad_done) pad_word[7:0] = SHAKE_DS_PAD;
    if (at_last) pad_word[W-1 -: 8] = pad_word[W-1 -: 8] | SHAKE_FINAL_PAD;
`endif
  end

  // Buffer write port: accepted word in FILL, generated word in PAD
  always_comb begin
    buf_we    = 1'b0;
    buf_wdata = '0;
    case (state)
      FILL: begin
        if (accept) begin
          buf_we    = 1'b1;
          buf_wdata = bus.last_in ? last_word : bus.data_in;
        end
      end
      PAD: begin
        buf_we    = 1'b1;
        buf_wdata = pad_word;
      end
      default: ;
    endcase
  end

  // Control FSM: state, word counter, padding flags, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      cnt           <= '0;
      block_valid_q <= 1'b0;
      last_block_q  <= 1'b0;
`ifdef ABSORB_PAD_EN
      pad_done      <= 1'b0;
      pad_owed      <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (bus.last_in) begin
`ifdef ABSORB_PAD_EN
              if (last_k < NB) pad_done <= 1'b1;
              // A full last word in the final slot leaves no room for the
              // pad bytes, so a separate all-padding block is owed.
              if (at_last) begin
                state         <= FULL;
                block_valid_q <= 1'b1;
                last_block_q  <= (last_k < NB);
                pad_owed      <= (last_k >= NB);
              end else begin
                state <= PAD;
              end
`else
              if (at_last) begin
                state         <= FULL;
                block_valid_q <= 1'b1;
                last_block_q  <= 1'b1;
              end else begin
                state <= PAD;
              end
`endif
            end else if (at_last) begin
              state         <= FULL;
              block_valid_q <= 1'b1;
              last_block_q  <= 1'b0;
            end
          end
        end
        PAD: begin
          cnt <= cnt + CNT_W'(1);
`ifdef ABSORB_PAD_EN
          pad_done <= 1'b1;
`endif
          if (at_last) begin
            state         <= FULL;
            block_valid_q <= 1'b1;
            last_block_q  <= 1'b1;
          end
        end
        FULL: begin
          if (bus.block_ack) begin
            cnt           <= '0;
            block_valid_q <= 1'b0;
            last_block_q  <= 1'b0;
`ifdef ABSORB_PAD_EN
            pad_done      <= 1'b0;
            if (pad_owed) begin
              pad_owed <= 1'b0;
              state    <= PAD;
            end else begin
              state <= FILL;
            end
`else
            state <= FILL;
`endif
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  absorb_buffer #(
    .W          (W),
    .RATE_WORDS (RATE_WORDS)
  ) u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (buf_we),
    .idx       (cnt),
    .wdata     (buf_wdata),
    .block_out (block_q)
  );

endmodule

// File: tb/tb_absorb_fsm.sv
// Directed self-checking bench for absorb_fsm (W=64, RATE_WORDS=21).
// Padding scenarios run when ABSORB_PAD_EN is defined, pass-through
// scenarios otherwise.
module tb_absorb_fsm;

  localparam int W  = 64;
  localparam int RW = 21;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  logic [RW*W-1:0] exp_blk;

  absorb_fsm_if #(.W(W), .RATE_WORDS(RW)) bus ();

  absorb_fsm #(.W(W), .RATE_WORDS(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int unsigned seed, input int unsigned i);
    return {32'hC0DE0000 + 32'(seed), 32'h0BAD0000 + 32'(i) * 32'h00010101};
  endfunction

  task automatic drive_word(input logic [63:0] d, input logic last, input logic [3:0] k);
    bus.data_in       = d;
    bus.valid_in      = 1'b1;
    bus.last_in       = last;
    bus.last_bytes_in = k;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
  endtask

  task automatic send_words(input int unsigned seed, input int unsigned first, input int unsigned n);
    for (int unsigned i = first; i < first + n; i++) drive_word(pat(seed, i), 1'b0, 4'd8);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.block_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_ack();
    bus.block_ack = 1'b1;
    @(posedge clk); #1;
    bus.block_ack = 1'b0;
  endtask

  task automatic set_exp_data(input int unsigned seed, input int unsigned nwords);
    exp_blk = '0;
    for (int unsigned i = 0; i < nwords; i++) exp_blk[i*W +: W] = pat(seed, i);
  endtask

  task automatic test_reset();
    total++; if (bus.ready_out !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.ready_out); else passed++;
    total++; if (bus.block_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.block_valid); else passed++;
    total++; if (bus.last_block_out !== 1'b0) $display("FAIL reset_last: got %b expected 0", bus.last_block_out); else passed++;
    total++; if (bus.block_out !== '0) $display("FAIL reset_block: got %h expected 0", bus.block_out); else passed++;
  endtask

  task automatic test_full_block();
    send_words(1, 0, RW);
    set_exp_data(1, RW);
    total++; if (bus.block_valid !== 1'b1) $display("FAIL full_valid: got %b expected 1", bus.block_valid); else passed++;
    total++; if (bus.last_block_out !== 1'b0) $display("FAIL full_last: got %b expected 0", bus.last_block_out); else passed++;
    total++; if (bus.ready_out !== 1'b0) $display("FAIL full_ready: got %b expected 0", bus.ready_out); else passed++;
    total++; if (bus.block_out !== exp_blk) $display("FAIL full_block: got %h expected %h", bus.block_out, exp_blk); else passed++;
  endtask

  // Block from test_full_block is still waiting for its ack here
  task automatic test_stall();
    bus.data_in  = 64'hDEADBEEFDEADBEEF;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (bus.ready_out !== 1'b0) $display("FAIL stall_ready[%0d]: got %b expected 0", i, bus.ready_out); else passed++;
      total++; if (bus.block_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.block_valid); else passed++;
      total++; if (bus.block_out !== exp_blk) $display("FAIL stall_block[%0d]: got %h expected %h", i, bus.block_out, exp_blk); else passed++;
    end
    bus.valid_in = 1'b0;
    do_ack();
    total++; if (bus.block_valid !== 1'b0) $display("FAIL ack_valid: got %b expected 0", bus.block_valid); else passed++;
    total++; if (bus.ready_out !== 1'b1) $display("FAIL ack_ready: got %b expected 1", bus.ready_out); else passed++;
    send_words(2, 0, RW - 1);
    total++; if (bus.block_valid !== 1'b0) $display("FAIL stall_no_consume: got %b expected 0", bus.block_valid); else passed++;
    send_words(2, RW - 1, 1);
    set_exp_data(2, RW);
    total++; if (bus.block_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", bus.block_valid); else passed++;
    total++; if (bus.block_out !== exp_blk) $display("FAIL b2b_block: got %h expected %h", bus.block_out, exp_blk); else passed++;
    do_ack();
  endtask

  task automatic test_reset_mid();
    send_words(3, 0, 5);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.ready_out !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", bus.ready_out); else passed++;
    total++; if (bus.block_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", bus.block_valid); else passed++;
    total++; if (bus.block_out !== '0) $display("FAIL rstmid_block: got %h expected 0", bus.block_out); else passed++;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_words(4, 0, RW - 1);
    total++; if (bus.block_valid !== 1'b0) $display("FAIL rstmid_early: got %b expected 0", bus.block_valid); else passed++;
    send_words(4, RW - 1, 1);
    set_exp_data(4, RW);
    total++; if (bus.block_valid !== 1'b1) $display("FAIL rstmid_valid2: got %b expected 1", bus.block_valid); else passed++;
    total++; if (bus.block_out !== exp_blk) $display("FAIL rstmid_clean: got %h expected %h", bus.block_out, exp_blk); else passed++;
    do_ack();
  endtask

`ifndef ABSORB_PAD_EN
  task automatic test_last_nopad();
    int n;
    send_words(5, 0, 4);
    drive_word(pat(5, 4), 1'b1, 4'd3);
    wait_valid(n);
    set_exp_data(5, 5);
    total++; if (n !== 16) $display("FAIL nopad_pad_cycles: got %0d expected 16", n); else passed++;
    total++; if (bus.last_block_out !== 1'b1) $display("FAIL nopad_last: got %b expected 1", bus.last_block_out); else passed++;
    total++; if (bus.block_out !== exp_blk) $display("FAIL nopad_block: got %h expected %h", bus.block_out, exp_blk); else passed++;
    do_ack();
    total++; if (bus.ready_out !== 1'b1) $display("FAIL nopad_ready: got %b expected 1", bus.ready_out); else passed++;
  endtask

  task automatic test_last_full_nopad();
    send_words(6, 0, RW - 1);
    drive_word(pat(6, RW - 1), 1'b1, 4'd8);
    set_exp_data(6, RW);
    total++; if (bus.block_valid !== 1'b1) $display("FAIL nopadfull_valid: got %b expected 1", bus.block_valid); else passed++;
    total++; if (bus.last_block_out !== 1'b1) $display("FAIL nopadfull_last: got %b expected 1", bus.last_block_out); else passed++;
    total++; if (bus.block_out !== exp_blk) $display("FAIL nopadfull_block: got %h expected %h", bus.block_out, exp_blk); else passed++;
    do_ack();
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.block_valid !== 1'b0) $display("FAIL nopadfull_no_owed[%0d]: got %b expected 0", i, bus.block_valid); else passed++;
      total++; if (bus.ready_out !== 1'b1) $display("FAIL nopadfull_ready[%0d]: got %b expected 1", i, bus.ready_out); else passed++;
      @(posedge clk); #1;
    end
  endtask
`else
  task automatic test_owed_block();
    int n;
    send_words(7, 0, RW - 1);
    drive_word(pat(7, RW - 1), 1'b1, 4'd8);
    set_exp_data(7, RW);
    total++; if (bus.block_valid !== 1'b1) $display("FAIL owed_valid1: got %b expected 1", bus.block_valid); else passed++;
    total++; if (bus.last_block_out !== 1'b0) $display("FAIL owed_last1: got %b expected 0", bus.last_block_out); else passed++;
    total++; if (bus.block_out !== exp_blk) $display("FAIL owed_block1: got %h expected %h", bus.block_out, exp_blk); else passed++;
    do_ack();
    total++; if (bus.ready_out !== 1'b0) $display("FAIL owed_ready_pad: got %b expected 0", bus.ready_out); else passed++;
    wait_valid(n);
    exp_blk = '0;
    exp_blk[0 +: W] = 64'h000000000000001F;
    exp_blk[20*W +: W] = 64'h8000000000000000;
    total++; if (n !== 21) $display("FAIL owed_pad_cycles: got %0d expected 21", n); else passed++;
    total++; if (bus.last_block_out !== 1'b1) $display("FAIL owed_last2: got %b expected 1", bus.last_block_out); else passed++;
    total++; if (bus.block_out !== exp_blk) $display("FAIL owed_block2: got %h expected %h", bus.block_out, exp_blk); else passed++;
    do_ack();
    total++; if (bus.ready_out !== 1'b1) $display("FAIL owed_ready: got %b expected 1", bus.ready_out); else passed++;
  endtask

  task automatic test_single_k3();
    int n;
    drive_word(64'h1122334455667788, 1'b1, 4'd3);
    wait_valid(n);
    exp_blk = '0;
    exp_blk[0 +: W] = 64'h000000001F667788;
    exp_blk[20*W +: W] = 64'h8000000000000000;
    total++; if (n !== 20) $display("FAIL k3_pad_cycles: got %0d expected 20", n); else passed++;
    total++; if (bus.last_block_out !== 1'b1) $display("FAIL k3_last: got %b expected 1", bus.last_block_out); else passed++;
    total++; if (bus.block_out !== exp_blk) $display("FAIL k3_block: got %h expected %h", bus.block_out, exp_blk); else passed++;
    do_ack();
  endtask

  task automatic test_k7_at_end();
    send_words(8, 0, RW - 1);
    drive_word(64'hFFEEDDCCBBAA9988, 1'b1, 4'd7);
    set_exp_data(8, RW - 1);
    exp_blk[20*W +: W] = 64'h9FEEDDCCBBAA9988;
    total++; if (bus.block_valid !== 1'b1) $display("FAIL k7_valid: got %b expected 1", bus.block_valid); else passed++;
    total++; if (bus.last_block_out !== 1'b1) $display("FAIL k7_last: got %b expected 1", bus.last_block_out); else passed++;
    total++; if (bus.block_out !== exp_blk) $display("FAIL k7_block: got %h expected %h", bus.block_out, exp_blk); else passed++;
    do_ack();
    total++; if (bus.ready_out !== 1'b1) $display("FAIL k7_ready: got %b expected 1", bus.ready_out); else passed++;
  endtask
`endif

  initial begin
    passed            = 0;
    total             = 0;
    exp_blk           = '0;
    rst_n             = 1'b0;
    bus.data_in       = '0;
    bus.valid_in      = 1'b0;
    bus.last_in       = 1'b0;
    bus.last_bytes_in = '0;
    bus.block_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_full_block();
    test_stall();
    test_reset_mid();
`ifndef ABSORB_PAD_EN
    test_last_nopad();
    test_last_full_nopad();
`else
    test_owed_block();
    test_single_k3();
    test_k7_at_end();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
